ysyx_23060077_axi_sram: RTL

YSYX_23060077_AXI_SRAM -- requirements
Module: ysyx_23060077_axi_sram

---
 rtl/ysyx_23060077_axi_sram_pkg.sv | 39 +++
 rtl/ysyx_23060077_axi_sram_if.sv | 47 ++++
 rtl/ysyx_23060077_lfsr8.sv | 23 ++
 rtl/ysyx_23060077_axi_sram.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_axi_sram_pkg.sv
// Shared widths, response codes, FSM encodings and byte-merge helper for the AXI SRAM.
// FSM encodings and OKAY/SLVERR codes live here so every SRAM file sees one definition.
package ysyx_23060077_axi_sram_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_RESP_WIDTH = 2;

  localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'd0;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  function automatic logic [AXI_DATA_WIDTH-1:0] merge_strb(
    input logic [AXI_DATA_WIDTH-1:0] old_w,
    input logic [AXI_DATA_WIDTH-1:0] new_w,
    input logic [AXI_STRB_WIDTH-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060077_axi_sram_if.sv
// AXI burst bus bundle between a master and the SRAM; slave modport is the SRAM side.
interface ysyx_23060077_axi_sram_if;
  import ysyx_23060077_axi_sram_pkg::*;

  logic                      axi_aw_valid_i;
  logic                      axi_aw_ready_o;
  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i;
  logic [AXI_LEN_WIDTH-1:0]  axi_aw_len_i;
  logic                      axi_w_valid_i;
  logic                      axi_w_ready_o;
  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i;
  logic [AXI_STRB_WIDTH-1:0] axi_w_strb_i;
  logic                      axi_w_last_i;
  logic                      axi_b_valid_o;
  logic                      axi_b_ready_i;
  logic [AXI_RESP_WIDTH-1:0] axi_b_resp_o;
  logic                      axi_ar_valid_i;
  logic                      axi_ar_ready_o;
  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i;
  logic [AXI_LEN_WIDTH-1:0]  axi_ar_len_i;
  logic                      axi_r_valid_o;
  logic                      axi_r_ready_i;
  logic [AXI_DATA_WIDTH-1:0] axi_r_data_o;
  logic [AXI_RESP_WIDTH-1:0] axi_r_resp_o;
  logic                      axi_r_last_o;

  modport slave (
    input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_len_i,
    input  axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    input  axi_b_ready_i,
    input  axi_ar_valid_i, axi_ar_addr_i, axi_ar_len_i,
    input  axi_r_ready_i,
    output axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o,
    output axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o
  );

  modport master (
    output axi_aw_valid_i, axi_aw_addr_i, axi_aw_len_i,
    output axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    output axi_b_ready_i,
    output axi_ar_valid_i, axi_ar_addr_i, axi_ar_len_i,
    output axi_r_ready_i,
    input  axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o,
    input  axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o
  );

endinterface

// File: rtl/ysyx_23060077_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5, stepping every cycle.
// Only built when YSYX_23060077_AXI_SRAM_RAND_DELAY_EN is defined.
`ifdef YSYX_23060077_AXI_SRAM_RAND_DELAY_EN
module ysyx_23060077_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr_o
);
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule
`endif

// File: rtl/ysyx_23060077_axi_sram.sv
// AXI INCR-burst SRAM slave: independent write and read engines over one word array.
// Define YSYX_23060077_AXI_SRAM_RAND_DELAY_EN to add LFSR-driven ready/valid stalls.
module ysyx_23060077_axi_sram
  import ysyx_23060077_axi_sram_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 1
) (
  input logic                     aclk,
  input logic                     areset_n,
  ysyx_23060077_axi_sram_if.slave axi
);
  localparam int         IDX_W        = $clog2(MEM_DEPTH);
  localparam logic [3:0] RD_WAIT_INIT = 4'(RD_LAT - 1);

  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [AXI_LEN_WIDTH-1:0] len_t;

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e                  w_state_q, w_state_d;
  idx_t                      w_idx_q, w_idx_d;
  len_t                      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                      w_err_q, w_err_d;
  logic [AXI_RESP_WIDTH-1:0] b_resp_q, b_resp_d;
  logic                      aw_ready, w_ready, b_valid, w_we;

  r_state_e                  r_state_q, r_state_d;
  idx_t                      r_idx_q, r_idx_d;
  len_t                      r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [3:0]                r_wait_q, r_wait_d;
  logic                      r_hold_q, r_hold_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                      ar_ready, r_valid, r_last;

  idx_t aw_idx, ar_idx;
  logic grant;
  logic unused_addr_bits;

  assign aw_idx = axi.axi_aw_addr_i[IDX_W+2:3];
  assign ar_idx = axi.axi_ar_addr_i[IDX_W+2:3];
  assign unused_addr_bits = ^{axi.axi_aw_addr_i[AXI_ADDR_WIDTH-1:IDX_W+3], axi.axi_aw_addr_i[2:0],
                              axi.axi_ar_addr_i[AXI_ADDR_WIDTH-1:IDX_W+3], axi.axi_ar_addr_i[2:0]};

`ifdef YSYX_23060077_AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;
  ysyx_23060077_lfsr8 u_lfsr8 (.clk(aclk), .rst(areset_n), .lfsr_o(lfsr));
  assign grant       = lfsr[0];
  assign unused_lfsr = ^lfsr[7:1];
`else
  assign grant = 1'b1;
`endif

  // areset_n is active-high; every output is forced low while it is set.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    b_resp_d  = b_resp_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    w_we      = 1'b0;
    if (!areset_n) begin
      case (w_state_q)
        W_IDLE: begin
          aw_ready = grant;
          if (axi.axi_aw_valid_i && aw_ready) begin
            w_idx_d   = aw_idx;
            w_len_d   = axi.axi_aw_len_i;
            w_cnt_d   = '0;
            w_err_d   = 1'b0;
            w_state_d = W_DATA;
          end
        end
        W_DATA: begin
          w_ready = grant;
          if (axi.axi_w_valid_i && w_ready) begin
            w_we    = 1'b1;
            w_idx_d = w_idx_q + idx_t'(1);
            w_cnt_d = w_cnt_q + len_t'(1);
            if (w_cnt_q == w_len_q) begin
              b_resp_d  = (w_err_q || !axi.axi_w_last_i) ? RESP_SLVERR : RESP_OKAY;
              w_state_d = W_RESP;
            end else if (axi.axi_w_last_i) begin
              w_err_d = 1'b1;
            end
          end
        end
        W_RESP: begin
          b_valid = 1'b1;
          if (axi.axi_b_ready_i) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  // r_data is captured into a register so it holds across stalls and same-edge writes.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_wait_d  = r_wait_q;
    r_hold_d  = r_hold_q;
    r_data_d  = r_data_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_last    = 1'b0;
    if (!areset_n) begin
      case (r_state_q)
        R_IDLE: begin
          ar_ready = grant;
          if (axi.axi_ar_valid_i && ar_ready) begin
            r_idx_d  = ar_idx;
            r_len_d  = axi.axi_ar_len_i;
            r_cnt_d  = '0;
            r_hold_d = 1'b0;
            if (RD_LAT == 0) begin
              r_data_d  = mem_q[ar_idx];
              r_state_d = R_DATA;
            end else begin
              r_wait_d  = RD_WAIT_INIT;
              r_state_d = R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_q == 4'd0) begin
            r_data_d  = mem_q[r_idx_q];
            r_state_d = R_DATA;
          end else begin
            r_wait_d = r_wait_q - 4'd1;
          end
        end
        R_DATA: begin
          r_valid = r_hold_q || grant;
          r_last  = r_valid && (r_cnt_q == r_len_q);
          if (r_valid && axi.axi_r_ready_i) begin
            r_hold_d = 1'b0;
            if (r_cnt_q == r_len_q) begin
              r_state_d = R_IDLE;
            end else begin
              r_idx_d  = r_idx_q + idx_t'(1);
              r_cnt_d  = r_cnt_q + len_t'(1);
              r_data_d = mem_q[r_idx_q + idx_t'(1)];
            end
          end else begin
            r_hold_d = r_valid;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset_n) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_wait_q  <= '0;
      r_hold_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_wait_q  <= r_wait_d;
      r_hold_q  <= r_hold_d;
      r_data_q  <= r_data_d;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge aclk) begin
    if (w_we) mem_q[w_idx_q] <= merge_strb(mem_q[w_idx_q], axi.axi_w_data_i, axi.axi_w_strb_i);
  end

  assign axi.axi_aw_ready_o = aw_ready;
  assign axi.axi_w_ready_o  = w_ready;
  assign axi.axi_b_valid_o  = b_valid;
  assign axi.axi_b_resp_o   = b_valid ? b_resp_q : RESP_OKAY;
  assign axi.axi_ar_ready_o = ar_ready;
  assign axi.axi_r_valid_o  = r_valid;
  assign axi.axi_r_data_o   = areset_n ? '0 : r_data_q;
  assign axi.axi_r_resp_o   = RESP_OKAY;
  assign axi.axi_r_last_o   = r_last;

endmodule
